serial_rx: RTL and testbench
============================

# serial_rx

Parametrised asynchronous serial receiver: the next-generation line receiver for the serial transceiver. It oversamples a single-wire input with an internal tick divider, qualifies start bits and votes each bit by majority at mid-bit. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Received words are held in an output register with a valid/ack handshake, and parity, framing and overrun errors are flagged.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥ 4.
- `CLKS_PER_SAMPLE`, 1: `clk` cycles per sample tick; ≥ 1.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `din`  in  1  asynchronous serial line; idle high.
- `rx_ack`  in  1  consumer acknowledge; consumes the held word when `rx_valid` = 1.
- `rx_data`  out  `DATA_BITS`  received word; bit 0 is the first bit on the line.
- `rx_valid`  out  1  word held and unacknowledged.
- `rx_parity_err`  out  1  parity mismatch for the held word.
- `rx_frame_err`  out  1  a stop bit was sampled low for the held word.
- `rx_overrun`  out  1  sticky; a frame completed while `rx_valid` = 1 and was dropped.

## Operation
- **Reset values** (when `rst_n` = 0 at a `clk` edge):
  - `rx_data`, `rx_valid`, both error flags and `rx_overrun` = 0.
  - FSM in IDLE; divider and sample counter = 0.
  - Both synchroniser flops and the 3-sample vote window = 1.
- **Synchroniser:** `din` passes through 2 flops to give `din_s`.
- **Tick divider:**
  - Free-running counter over 0..`CLKS_PER_SAMPLE`−1.
  - `tick` = 1 when the counter is at `CLKS_PER_SAMPLE`−1.
  - With `CLKS_PER_SAMPLE` = 1, `tick` = 1 every cycle.
- **Vote window:**
  - On each tick, `din_s` shifts into a 3-bit window.
  - `vote` = majority of the window after the shift.
  - The FSM acts only on tick cycles.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE: `din_s` = 0 → START with `scnt` = 1.
  - START: `scnt` increments.
    - At `scnt` = `OVERSAMPLE`/2−1, `vote` = 1 → IDLE (glitch rejected, no output).
    - Otherwise `scnt` = 0 and go to DATA.
  - DATA: `scnt` increments.
    - At `scnt` = `OVERSAMPLE`−1, `vote` shifts in LSB-first: shift right, `vote` enters the MSB.
    - Then `scnt` = 0 and `bidx` increments.
    - After `DATA_BITS` samples → PAR if `PARITY` ≠ 0, else STOP.
  - PAR: at mid-bit, perr = XOR(data bits, `vote`) XOR (`PARITY` = 1), i.e. odd mode expects a total XOR of 1.
  - STOP: samples `STOP_BITS` mid-bits.
    - ferr = 1 if any stop sample is 0.
    - After the last stop sample → IDLE immediately, so the next start edge is accepted from mid-stop onward.
- **Delivery**, on the edge that registers the last stop sample:
  - If `rx_valid` = 0, or `rx_ack` = 1 in the same cycle: load `rx_data`, `rx_parity_err`, `rx_frame_err`; `rx_valid` = 1.
  - Otherwise: drop the frame and set `rx_overrun` = 1; held data and flags are unchanged.
- **Acknowledge:**
  - `rx_ack` with `rx_valid` = 1 and no delivery that cycle → `rx_valid` = 0 and `rx_overrun` = 0 on the next edge.
  - `rx_ack` with `rx_valid` = 0 is ignored.
- **Error frames:** the word is delivered even on parity or frame error; only the flags distinguish it.
- **Reset mid-frame:** the partial frame is discarded and the FSM returns to IDLE. The input is re-synchronised from the reset value 1, so a line already low after reset is detected as a start bit after 2 cycles.

## Timing
- Input latency: 2 `clk` cycles through the synchroniser.
- Start detect to start qualify: `OVERSAMPLE`/2 ticks.
- Each data, parity and stop bit is sampled `OVERSAMPLE` ticks after the previous sample.
- With `CLKS_PER_SAMPLE` = 1, `OVERSAMPLE` = 16, 8N1: `rx_valid` rises 2 + 8 + 9×16 = 154 ±1 `clk` after the start-bit falling edge on `din`.
- `rx_valid` stays high until acknowledged; there is no timeout.
- Outputs are registered and change only on `clk` edges.
- Frame rate: back-to-back frames with one stop bit are received with no idle gap.
- Baud tolerance: ±3 % baud mismatch is received without error at `OVERSAMPLE` = 16.

## Test plan
- 8N1 reception (defaults): send 0xA5, bit period 16 clk → `rx_data` = 0xA5, `rx_valid` at 154 ±1 clk, both error flags 0; pulse `rx_ack` → `rx_valid` = 0 next cycle.
- Even parity, 7 data bits (`PARITY` = 2, `DATA_BITS` = 7): send 0x55 with correct parity 0 → `rx_parity_err` = 0; resend with parity 1 → `rx_data` = 0x55, `rx_parity_err` = 1.
- Framing error, 2 stop bits (`STOP_BITS` = 2): send 0x3C with the second stop bit low → `rx_frame_err` = 1 and `rx_data` = 0x3C; the following good frame 0x81 is received cleanly.
- Glitch rejection and noise voting:
  - 3-clk low pulse on idle `din` → no `rx_valid`, FSM back in IDLE.
  - 1-clk inverted spike at the centre of a data bit of frame 0xF0 → `rx_data` = 0xF0.
- Overrun and same-cycle ack:
  - Send 0x11 then 0x22 back-to-back with no ack → `rx_data` = 0x11, `rx_overrun` = 1; ack clears both `rx_valid` and `rx_overrun`.
  - Repeat with `rx_ack` asserted on the delivery cycle of the second frame → `rx_data` = 0x22, `rx_valid` = 1, `rx_overrun` = 0.
- Reset mid-frame: assert `rst_n` = 0 for 1 clk during data bit 4 of frame 0x99 → all outputs 0, no delivery; the next frame 0x42 is received correctly.

Source files
------------

// File: rtl/serial_rx.sv
// Oversampling asynchronous serial receiver: 2-flop synchroniser, tick divider,
// 3-sample majority vote at mid-bit, 5-9 data bits, optional parity, 1-2 stop bits.
module serial_rx #(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE      = 16,
  parameter int CLKS_PER_SAMPLE = 1,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int DW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
  localparam logic          SI_LAST  = 1'(STOP_BITS - 1);
  localparam logic          ODD      = 1'(PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 din_s;
  logic [DW-1:0]        div;
  logic                 tick;
  logic [1:0]           win;
  logic                 vote;
  logic [SW-1:0]        scnt, scnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic                 sidx, sidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr_q, perr_n, ferr_q, ferr_n;
  logic                 done;

  assign din_s = sync[1];
  assign tick  = (div == DIV_LAST);
  // The two stored samples plus the incoming one form the window after the shift.
  assign vote  = (win[1] & win[0]) | (win[1] & din_s) | (win[0] & din_s);

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bidx_n  = bidx;
    sidx_n  = sidx;
    shreg_n = shreg;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    done    = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: if (!din_s) begin
          state_n = START;
          scnt_n  = SW'(1);
          bidx_n  = '0;
          sidx_n  = 1'b0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
        START: if (scnt == S_MID) begin
          scnt_n  = '0;
          state_n = vote ? IDLE : DATA;
        end else scnt_n = scnt + 1'b1;
        DATA: if (scnt == S_END) begin
          scnt_n  = '0;
          shreg_n = {vote, shreg[DATA_BITS-1:1]};
          bidx_n  = bidx + 1'b1;
          if (bidx == B_LAST) state_n = (PARITY != 0) ? PAR : STOP;
        end else scnt_n = scnt + 1'b1;
        PAR: if (scnt == S_END) begin
          scnt_n  = '0;
          perr_n  = (^shreg) ^ vote ^ ODD;
          state_n = STOP;
        end else scnt_n = scnt + 1'b1;
        STOP: if (scnt == S_END) begin
          scnt_n = '0;
          ferr_n = ferr_q | ~vote;
          // Leave at mid-stop so a start edge right after the stop bit is caught.
          if (sidx == SI_LAST) begin
            state_n = IDLE;
            done    = 1'b1;
          end else sidx_n = sidx + 1'b1;
        end else scnt_n = scnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync          <= 2'b11;
      div           <= '0;
      win           <= 2'b11;
      state         <= IDLE;
      scnt          <= '0;
      bidx          <= '0;
      sidx          <= 1'b0;
      shreg         <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      div   <= tick ? '0 : div + 1'b1;
      if (tick) win <= {win[0], din_s};
      state  <= state_n;
      scnt   <= scnt_n;
      bidx   <= bidx_n;
      sidx   <= sidx_n;
      shreg  <= shreg_n;
      perr_q <= perr_n;
      ferr_q <= ferr_n;
      if (done) begin
        if (!rx_valid || rx_ack) begin
          rx_data       <= shreg;
          rx_parity_err <= perr_q;
          rx_frame_err  <= ferr_n;
          rx_valid      <= 1'b1;
        end else rx_overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: three instances (8N1, 7E1, 8N2), bit period 16 clk.
module tb_serial_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] din, ack, v, pe, fe, ov;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [8:0] rd [3];
  int checks = 0, failures = 0;

  typedef struct {
    int          u;
    logic [15:0] bits;
    int          n;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  serial_rx u0 (.clk(clk), .rst_n(rst_n), .din(din[0]), .rx_ack(ack[0]), .rx_data(d0),
                .rx_valid(v[0]), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_overrun(ov[0]));
  serial_rx #(.DATA_BITS(7), .PARITY(2)) u1 (.clk(clk), .rst_n(rst_n), .din(din[1]), .rx_ack(ack[1]),
                .rx_data(d1), .rx_valid(v[1]), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_overrun(ov[1]));
  serial_rx #(.STOP_BITS(2)) u2 (.clk(clk), .rst_n(rst_n), .din(din[2]), .rx_ack(ack[2]), .rx_data(d2),
                .rx_valid(v[2]), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_overrun(ov[2]));

  always_comb begin
    rd[0] = {1'b0, d0};
    rd[1] = {2'b0, d1};
    rd[2] = {1'b0, d2};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives n frame bits LSB first; entered and left just after a rising edge.
  task automatic send_bits(input int u, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      din[u] = b[i];
      repeat (16) @(posedge clk);
      #1;
    end
    din[u] = 1'b1;
  endtask

  task automatic pulse_ack(input int u);
    @(posedge clk); #1 ack[u] = 1'b1;
    @(posedge clk); #1 ack[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    din = '1;
    ack = '0;
    vecs[0] = '{0, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10, 9'h03C, 1'b0, 1'b0};
    vecs[1] = '{0, {6'h3F, 1'b1, 8'h00, 1'b0}, 10, 9'h000, 1'b0, 1'b0};
    vecs[2] = '{0, {6'h3F, 1'b1, 8'hFF, 1'b0}, 10, 9'h0FF, 1'b0, 1'b0};
    vecs[3] = '{1, {6'h3F, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 9'h055, 1'b0, 1'b0};
    vecs[4] = '{1, {6'h3F, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 9'h055, 1'b1, 1'b0};
    vecs[5] = '{1, {6'h3F, 1'b1, 1'b1, 7'h01, 1'b0}, 10, 9'h001, 1'b0, 1'b0};
    vecs[6] = '{1, {6'h3F, 1'b1, 1'b0, 7'h01, 1'b0}, 10, 9'h001, 1'b1, 1'b0};
    vecs[7] = '{2, {5'h1F, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 9'h081, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_data%0d", u), 32'(rd[u]), 0);
      chk($sformatf("rst_flags%0d", u), 32'({v[u], pe[u], fe[u], ov[u]}), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(5);

    // 8N1 0xA5 with latency from the falling start edge
    lat = 0;
    fork
      send_bits(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
      begin
        while (!v[0] && lat < 300) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    checks++;
    if (lat < 153 || lat > 155) begin
      failures++;
      $display("FAIL latency actual=%0d expected=154+-1", lat);
    end
    @(negedge clk);
    chk("a5_data", 32'(d0), 32'hA5);
    chk("a5_flags", 32'({v[0], pe[0], fe[0]}), 32'b100);
    pulse_ack(0);
    @(negedge clk);
    chk("a5_ack_valid", 32'(v[0]), 0);
    idle(10);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_bits(vecs[i].u, vecs[i].bits, vecs[i].n);
      idle(4);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(v[vecs[i].u]), 1);
      chk($sformatf("vec%0d_data", i), 32'(rd[vecs[i].u]), 32'(vecs[i].data));
      chk($sformatf("vec%0d_perr", i), 32'(pe[vecs[i].u]), 32'(vecs[i].perr));
      chk($sformatf("vec%0d_ferr", i), 32'(fe[vecs[i].u]), 32'(vecs[i].ferr));
      pulse_ack(vecs[i].u);
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), 32'(v[vecs[i].u]), 0);
      idle(10);
    end

    // 8N2: second stop bit low at its centre, then line recovers before the bit ends
    send_bits(2, {6'h3F, 1'b1, 8'h3C, 1'b0}, 10);
    din[2] = 1'b0;
    idle(10);
    din[2] = 1'b1;
    idle(40);
    @(negedge clk);
    chk("ferr_valid", 32'(v[2]), 1);
    chk("ferr_data", 32'(d2), 32'h3C);
    chk("ferr_flag", 32'(fe[2]), 1);
    pulse_ack(2);
    send_bits(2, {5'h1F, 1'b1, 1'b1, 8'h81, 1'b0}, 11);
    idle(4);
    @(negedge clk);
    chk("after_ferr_data", 32'(d2), 32'h81);
    chk("after_ferr_flags", 32'({v[2], pe[2], fe[2]}), 32'b100);
    pulse_ack(2);
    idle(10);

    // 3-clk glitch on idle line must not start a frame
    din[0] = 1'b0;
    idle(3);
    din[0] = 1'b1;
    idle(200);
    @(negedge clk);
    chk("glitch_no_valid", 32'(v[0]), 0);
    idle(2);

    // 0xF0 with a 1-clk low spike on the last sample of data bit 5's vote window
    send_bits(0, {6'h3F, 1'b1, 8'hF0, 1'b0}, 6);
    din[0] = 1'b1;
    idle(7);
    din[0] = 1'b0;
    idle(1);
    din[0] = 1'b1;
    idle(8);
    send_bits(0, {9'h1FF, 1'b1, 6'b111}, 3);
    idle(4);
    @(negedge clk);
    chk("spike_valid", 32'(v[0]), 1);
    chk("spike_data", 32'(d0), 32'hF0);
    pulse_ack(0);
    idle(10);

    // Overrun: two back-to-back frames, no ack
    send_bits(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
    idle(4);
    @(negedge clk);
    chk("ovr_data", 32'(d0), 32'h11);
    chk("ovr_flags", 32'({v[0], ov[0]}), 32'b11);
    pulse_ack(0);
    @(negedge clk);
    chk("ovr_ack_clears", 32'({v[0], ov[0]}), 0);
    idle(10);

    // Ack on the delivery edge of the second frame replaces the held word
    fork
      begin
        send_bits(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
      end
      begin
        repeat (313) @(posedge clk);
        #1 ack[0] = 1'b1;
        @(posedge clk); #1 ack[0] = 1'b0;
      end
    join
    @(negedge clk);
    chk("same_ack_data", 32'(d0), 32'h22);
    chk("same_ack_flags", 32'({v[0], ov[0]}), 32'b10);
    pulse_ack(0);
    idle(10);

    // Reset during data bit 4 of 0x99
    send_bits(0, {6'h3F, 1'b1, 8'h99, 1'b0}, 5);
    din[0] = 1'b1;
    idle(8);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(d0), 0);
    chk("midrst_flags", 32'({v[0], pe[0], fe[0], ov[0]}), 0);
    idle(200);
    @(negedge clk);
    chk("midrst_no_delivery", 32'(v[0]), 0);
    idle(2);
    send_bits(0, {6'h3F, 1'b1, 8'h42, 1'b0}, 10);
    idle(4);
    @(negedge clk);
    chk("post_rst_data", 32'(d0), 32'h42);
    chk("post_rst_flags", 32'({v[0], pe[0], fe[0], ov[0]}), 32'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
